// File: rtl/if_id_buffer_pkg.sv
// Shared constants for the fetch/decode decoupling buffer.
// These stand in for the legacy ZeroWord / InstBus / InstAddrBus / NopInst defines.
package if_id_buffer_pkg;

    localparam int          INST_BUS_W      = 32;
    localparam int          INST_ADDR_BUS_W = 32;
    localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
    localparam logic [31:0] NOP_INST        = 32'h0000_0000;

endpackage

// File: rtl/if_id_buf_mem.sv
// Entry storage for the IF/ID buffer: one synchronous write port and one asynchronous read port.
// Contents are not reset; occupancy tracking in the parent decides which entries are meaningful.
module if_id_buf_mem
    import if_id_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = INST_ADDR_BUS_W + INST_BUS_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_buffer.sv
// In-order {pc, inst} buffer between fetch and decode with valid/ready on both sides and
// a one-cycle flush. Optional stall counter port stall_cnt_o under `IF_ID_BUF_PERF_EN.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int          DEPTH = 2,
    parameter int          AW    = INST_ADDR_BUS_W,
    parameter int          DW    = INST_BUS_W,
    parameter logic [DW-1:0] NOP = DW'(NOP_INST)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AW-1:0]            if_pc_i,
    input  logic [DW-1:0]            if_inst_i,
    input  logic                     if_valid_i,
    output logic                     if_ready_o,
    output logic [AW-1:0]            id_pc_o,
    output logic [DW-1:0]            id_inst_o,
    output logic                     id_valid_o,
    input  logic                     id_ready_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef IF_ID_BUF_PERF_EN
    ,
    output logic [31:0]              stall_cnt_o
`endif
);

    localparam int              PW   = $clog2(DEPTH);
    localparam int              CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push;
    logic             pop;
    logic [AW+DW-1:0] rd_entry;

    // Ready depends only on registered occupancy, so a full buffer cannot refill on a pop cycle.
    assign if_ready_o = (count_q != FULL);
    assign id_valid_o = (count_q != '0);
    assign push       = if_valid_i & if_ready_o;
    assign pop        = id_valid_o & id_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    if_id_buf_mem #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush_i),
        .waddr (wr_ptr_q),
        .wdata ({if_pc_i, if_inst_i}),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    assign id_pc_o   = id_valid_o ? rd_entry[AW+DW-1:DW] : AW'(ZERO_WORD);
    assign id_inst_o = id_valid_o ? rd_entry[DW-1:0]     : NOP;
    assign count_o   = count_q;

`ifdef IF_ID_BUF_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] stall_cnt_q;

    // Survives flush so stall statistics span redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (if_valid_i && !if_ready_o) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer (DEPTH=2); stall counter checks run when IF_ID_BUF_PERF_EN is defined.
module tb_if_id_buffer;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc_i;
    logic [31:0] if_inst_i;
    logic        if_valid_i;
    logic        if_ready_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        id_ready_i;
    logic        flush_i;
    logic [1:0]  count_o;
`ifdef IF_ID_BUF_PERF_EN
    logic [31:0] stall_cnt_o;
`endif

    int     vectors;
    int     miscompares;
    entry_t sb[$];

    if_id_buffer #(.DEPTH(2), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_pc_i    (if_pc_i),
        .if_inst_i  (if_inst_i),
        .if_valid_i (if_valid_i),
        .if_ready_o (if_ready_o),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_valid_o (id_valid_o),
        .id_ready_i (id_ready_i),
        .flush_i    (flush_i),
        .count_o    (count_o)
`ifdef IF_ID_BUF_PERF_EN
        ,
        .stall_cnt_o(stall_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Scoreboard consumer: every decode handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && !flush_i && id_valid_o && id_ready_i) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got pc=%h inst=%h, expected no output", id_pc_o, id_inst_o);
            end else begin
                entry_t e;
                e = sb.pop_front();
                if (id_pc_o !== e.pc || id_inst_o !== e.inst) begin
                    miscompares++;
                    $display("FAIL sb_data: got pc=%h inst=%h, expected pc=%h inst=%h",
                             id_pc_o, id_inst_o, e.pc, e.inst);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        if_valid_i = v;
        if_pc_i    = pc;
        if_inst_i  = inst;
    endtask

    task automatic expect_sb(input logic [31:0] pc, input logic [31:0] inst);
        entry_t e;
        e.pc   = pc;
        e.inst = inst;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        vectors++;
        if (id_valid_o !== 1'b0 || id_inst_o !== 32'h0 || id_pc_o !== 32'h0 ||
            count_o !== 2'd0 || if_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b inst=%h pc=%h count=%0d ready=%b, expected 0/0/0/0/1",
                     id_valid_o, id_inst_o, id_pc_o, count_o, if_ready_o);
        end
`ifdef IF_ID_BUF_PERF_EN
        vectors++;
        if (stall_cnt_o !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_stall_cnt: got %0d, expected 0", stall_cnt_o);
        end
`endif
        tick();
    endtask

    task automatic test_streaming();
        id_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(4 * i), 32'(8'h11 * (i + 1)));
            expect_sb(32'(4 * i), 32'(8'h11 * (i + 1)));
            vectors++;
            if (id_valid_o !== (i > 0) || count_o > 2'd1) begin
                miscompares++;
                $display("FAIL stream_latency[%0d]: got valid=%b count=%0d, expected valid=%b count<=1",
                         i, id_valid_o, count_o, (i > 0));
            end
            tick();
        end
        drive(1'b0, 32'h0, 32'h0);
        vectors++;
        if (id_valid_o !== 1'b1 || count_o !== 2'd1) begin
            miscompares++;
            $display("FAIL stream_tail: got valid=%b count=%0d, expected 1/1", id_valid_o, count_o);
        end
        tick();
        vectors++;
        if (id_valid_o !== 1'b0 || count_o !== 2'd0) begin
            miscompares++;
            $display("FAIL stream_drain: got valid=%b count=%0d, expected 0/0", id_valid_o, count_o);
        end
    endtask

    task automatic test_back_pressure();
        id_ready_i = 1'b0;
        drive(1'b1, 32'h20, 32'hA0);
        expect_sb(32'h20, 32'hA0);
        tick();
        drive(1'b1, 32'h24, 32'hA4);
        expect_sb(32'h24, 32'hA4);
        vectors++;
        if (if_ready_o !== 1'b1 || count_o !== 2'd1) begin
            miscompares++;
            $display("FAIL bp_one: got ready=%b count=%0d, expected 1/1", if_ready_o, count_o);
        end
        tick();
        drive(1'b1, 32'h28, 32'hA8);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (if_ready_o !== 1'b0 || count_o !== 2'd2 || id_pc_o !== 32'h20 || id_inst_o !== 32'hA0) begin
                miscompares++;
                $display("FAIL bp_full[%0d]: got ready=%b count=%0d pc=%h inst=%h, expected 0/2/20/a0",
                         k, if_ready_o, count_o, id_pc_o, id_inst_o);
            end
            tick();
        end
        // Release: pop happens, but the full buffer must not accept this cycle.
        id_ready_i = 1'b1;
        vectors++;
        if (if_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release_ready: got %b, expected 0", if_ready_o);
        end
        tick();
        vectors++;
        if (if_ready_o !== 1'b1 || count_o !== 2'd1) begin
            miscompares++;
            $display("FAIL bp_after_release: got ready=%b count=%0d, expected 1/1", if_ready_o, count_o);
        end
        expect_sb(32'h28, 32'hA8);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        tick();
        vectors++;
        if (count_o !== 2'd0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL bp_drain: got count=%0d pending=%0d, expected 0/0", count_o, sb.size());
        end
    endtask

    task automatic test_flush();
        id_ready_i = 1'b0;
        drive(1'b1, 32'h40, 32'hB0);
        tick();
        drive(1'b1, 32'h44, 32'hB4);
        tick();
        flush_i = 1'b1;
        drive(1'b1, 32'h100, 32'hCC);
        sb.delete();
        tick();
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        vectors++;
        if (count_o !== 2'd0 || id_valid_o !== 1'b0 || if_ready_o !== 1'b1 || id_inst_o !== 32'h0) begin
            miscompares++;
            $display("FAIL flush_full: got count=%0d valid=%b ready=%b inst=%h, expected 0/0/1/0",
                     count_o, id_valid_o, if_ready_o, id_inst_o);
        end
        // Flush with room available: the concurrent push must still be dropped.
        drive(1'b1, 32'h48, 32'hB8);
        tick();
        flush_i = 1'b1;
        drive(1'b1, 32'h100, 32'hCD);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        vectors++;
        if (count_o !== 2'd0 || id_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_push_drop: got count=%0d valid=%b, expected 0/0", count_o, id_valid_o);
        end
        id_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (id_valid_o !== 1'b0 || id_pc_o === 32'h100) begin
                miscompares++;
                $display("FAIL flush_ghost[%0d]: got valid=%b pc=%h, expected valid=0", k, id_valid_o, id_pc_o);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        id_ready_i = 1'b1;
        drive(1'b1, 32'h200, 32'hD0);
        expect_sb(32'h200, 32'hD0);
        tick();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 32'h200 + 32'(4 * k), 32'hD0 + 32'(k));
            expect_sb(32'h200 + 32'(4 * k), 32'hD0 + 32'(k));
            vectors++;
            if (count_o !== 2'd1 || if_ready_o !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap_count[%0d]: got count=%0d ready=%b, expected 1/1", k, count_o, if_ready_o);
            end
            tick();
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        vectors++;
        if (count_o !== 2'd0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_drain: got count=%0d pending=%0d, expected 0/0", count_o, sb.size());
        end
    endtask

    task automatic test_mid_reset();
        id_ready_i = 1'b0;
        drive(1'b1, 32'h300, 32'hE0);
        tick();
        drive(1'b1, 32'h304, 32'hE4);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (count_o !== 2'd0 || id_valid_o !== 1'b0 || if_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: got count=%0d valid=%b ready=%b, expected 0/0/1",
                     count_o, id_valid_o, if_ready_o);
        end
        drive(1'b0, 32'h0, 32'h0);
        sb.delete();
        #10 rst = 1'b0;
        tick();
        vectors++;
        if (count_o !== 2'd0 || id_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: got count=%0d valid=%b, expected 0/0", count_o, id_valid_o);
        end
    endtask

`ifdef IF_ID_BUF_PERF_EN
    task automatic test_perf();
        id_ready_i = 1'b0;
        vectors++;
        if (stall_cnt_o !== 32'd0) begin
            miscompares++;
            $display("FAIL perf_start: got %0d, expected 0", stall_cnt_o);
        end
        drive(1'b1, 32'h400, 32'hF0);
        tick();
        drive(1'b1, 32'h404, 32'hF4);
        tick();
        drive(1'b1, 32'h408, 32'hF8);
        for (int k = 0; k < 7; k++) tick();
        drive(1'b0, 32'h0, 32'h0);
        vectors++;
        if (stall_cnt_o !== 32'd7) begin
            miscompares++;
            $display("FAIL perf_stalls: got %0d, expected 7", stall_cnt_o);
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        vectors++;
        if (stall_cnt_o !== 32'd7 || count_o !== 2'd0) begin
            miscompares++;
            $display("FAIL perf_flush: got stall=%0d count=%0d, expected 7/0", stall_cnt_o, count_o);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        flush_i     = 1'b0;
        id_ready_i  = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #195 rst = 1'b0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_wrap();
        test_mid_reset();
`ifdef IF_ID_BUF_PERF_EN
        test_perf();
`endif
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d pending entries, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
